// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU pipeline stages.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 64;

    // Data-memory access controller states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FAULT
    } mem_state_t;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  mem_write;
    } exmem_t;

endpackage

// File: rtl/mem_wait_ctrl.sv
// Data-memory handshake controller: tracks outstanding accesses, counts wait
// cycles, and faults an access that is not acknowledged in time.
module mem_wait_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic memop,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall,
    output logic fault,
    output logic mem_err
);

    localparam int unsigned      CntW   = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(TIMEOUT);

    mem_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Handshake outputs derived from the registered instruction and state.
    // An ack always coincides with an EX/MEM reload, so a completed access
    // never lingers and no separate completion flag is required.
    always_comb begin
        mem_req = memop & (state_q != FAULT);
        stall   = mem_req & ~mem_ack;
        fault   = (state_q == FAULT);
        mem_err = err_q;
    end

    // Next-state, wait counter and sticky error flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d = WAIT;
                    cnt_d   = CntW'(1);
                end
            end
            WAIT: begin
                if (mem_req && mem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory interface, write-back mux
// and MEM/WB register.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_write,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write,
    output logic                  mem_err
);

    exmem_t                mreg_q, mreg_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic                  memop;
    logic                  fault;

    assign memop = mreg_q.valid & (mreg_q.mem_to_reg | mreg_q.mem_write);

    mem_wait_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctrl (
        .clk     (clk),
        .reset   (reset),
        .memop   (memop),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .stall   (stall),
        .fault   (fault),
        .mem_err (mem_err)
    );

    // Memory interface outputs, forced to zero when no request is active
    always_comb begin
        mem_we    = mem_req & mreg_q.mem_write;
        mem_addr  = mem_req ? mreg_q.result : '0;
        mem_wdata = mem_req ? mreg_q.store_data : '0;
    end

    // EX/MEM next state: hold while stalled, otherwise take the EX outputs
    always_comb begin
        mreg_d = mreg_q;
        if (!stall) begin
            mreg_d.valid      = ex_valid;
            mreg_d.result     = ex_result;
            mreg_d.store_data = ex_store_data;
            mreg_d.rd         = ex_rd;
            mreg_d.mem_to_reg = ex_mem_to_reg;
            mreg_d.reg_write  = ex_reg_write;
            mreg_d.mem_write  = ex_mem_write;
        end
    end

    // MEM/WB next state: bubble on stall or fault, data/rd held for a bubble
    always_comb begin
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        if (!stall && !fault) begin
            wb_valid_d     = mreg_q.valid;
            wb_reg_write_d = mreg_q.valid & mreg_q.reg_write;
            wb_rd_d        = mreg_q.rd;
            wb_data_d      = mreg_q.mem_to_reg ? mem_rdata : mreg_q.result;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mreg_q         <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
        end else begin
            mreg_q         <= mreg_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and records the
// expected memory requests and write-backs; a responder models the memory
// device; a monitor checks every write-back against the scoreboard.
module tb_mem_stage;
    import cpu_pkg::*;

    localparam int unsigned TO  = 4;
    localparam int          KALU = 0;
    localparam int          KLD  = 1;
    localparam int          KST  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [63:0] ex_result;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_mem_to_reg;
    logic        ex_reg_write;
    logic        ex_mem_write;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_err;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_write  (ex_mem_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] data;
        int          cyc;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          delay;
    } req_exp_t;

    wb_exp_t     exq[$];
    req_exp_t    rq[$];
    req_exp_t    cur;
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] dev_mem [logic [63:0]];
    int          req_cnt = 0;
    bit          err_exp = 0;
    bit          mon_en  = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    // Instruction currently presented on the ex_* inputs
    bit          p_valid = 0;
    int          p_kind  = KALU;
    logic [63:0] p_res, p_sd;
    logic [4:0]  p_rd;
    bit          p_rw;
    int          p_delay;
    bit          took;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event not as required", name);
    endtask

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Reference model: what a captured instruction must do to memory and WB
    task automatic accept();
        bit       memop;
        wb_exp_t  e;
        req_exp_t r;
        if (!p_valid) return;
        memop = (p_kind != KALU);
        if (memop) begin
            r.we    = (p_kind == KST);
            r.addr  = p_res;
            r.wdata = p_sd;
            r.delay = p_delay;
            rq.push_back(r);
        end
        if (memop && p_delay > int'(TO)) begin
            err_exp = 1;
            return;
        end
        e.rd   = p_rd;
        e.rw   = p_rw;
        e.data = (p_kind == KLD) ? ref_read(p_res) : p_res;
        e.cyc  = edge_cnt + 1 + (memop ? p_delay : 0);
        exq.push_back(e);
        if (p_kind == KST) ref_mem[p_res] = p_sd;
    endtask

    // One clock cycle: capture bookkeeping, memory responder, stall check
    task automatic step();
        bit pre_stall, pre_reset, ackd;
        pre_stall = (stall === 1'b1);
        pre_reset = reset;
        took = 0;
        @(posedge clk);
        #1;
        if (pre_reset) begin
            exq.delete();
            rq.delete();
            req_cnt = 0;
            err_exp = 0;
            chk("rst_mem_req", 64'(mem_req), 64'd0);
            chk("rst_stall", 64'(stall), 64'd0);
            chk("rst_wb_valid", 64'(wb_valid), 64'd0);
            chk("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
            chk("rst_mem_err", 64'(mem_err), 64'd0);
        end else if (!pre_stall) begin
            accept();
            took = 1;
        end
        ackd      = 0;
        mem_ack   = 1'b0;
        mem_rdata = {$urandom, $urandom};
        if (reset) begin
            // memory device idle while the pipeline is being reset
        end else if (mem_req === 1'b1) begin
            if (req_cnt == 0) begin
                if (rq.size() == 0) begin
                    fail("req_unexpected");
                    cur.delay = 0;
                end else begin
                    cur = rq.pop_front();
                    chk("req_we", 64'(mem_we), 64'(cur.we));
                    chk("req_addr", mem_addr, cur.addr);
                    chk("req_wdata", mem_wdata, cur.wdata);
                end
            end
            if (req_cnt > int'(TO)) fail("req_too_long");
            if (req_cnt == cur.delay) begin
                ackd    = 1;
                mem_ack = 1'b1;
                if (mem_we) dev_mem[mem_addr] = mem_wdata;
                else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
                req_cnt = 0;
            end else begin
                req_cnt++;
            end
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
            chk("idle_we", 64'(mem_we), 64'd0);
            chk("idle_addr", mem_addr, 64'd0);
            chk("idle_wdata", mem_wdata, 64'd0);
            if (req_cnt != 0) begin
                chk("fault_req_len", 64'(req_cnt), 64'(TO + 1));
                chk("fault_mem_err", 64'(mem_err), 64'd1);
                chk("fault_was_expected", 64'(cur.delay > int'(TO)), 64'd1);
                req_cnt = 0;
            end
        end
        #1;
        chk("stall", 64'(stall), 64'((mem_req === 1'b1) && !ackd));
    endtask

    task automatic issue(input bit v, input int kind, input logic [63:0] res,
                         input logic [63:0] sd, input logic [4:0] rd, input bit rw,
                         input int dly);
        bit ok;
        p_valid = v; p_kind = kind; p_res = res; p_sd = sd; p_rd = rd; p_rw = rw;
        p_delay = dly;
        ex_valid      = v;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_to_reg = v ? (kind == KLD) : 1'($urandom_range(0, 1));
        ex_mem_write  = v ? (kind == KST) : 1'($urandom_range(0, 1));
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (took) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("accept_timeout");
        p_valid  = 0;
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        p_valid  = 0;
        ex_valid = 1'b0;
        repeat (n) step();
    endtask

    // Monitor: every presented write-back must match the scoreboard head
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wb_valid === 1'b1) begin
                    if (exq.size() == 0) begin
                        fail("wb_unexpected");
                    end else begin
                        e = exq.pop_front();
                        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                        chk("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
                        chk("wb_data", wb_data, e.data);
                        chk("wb_cycle", 64'(edge_cnt), 64'(e.cyc));
                    end
                end else begin
                    chk("bubble_reg_write", 64'(wb_reg_write), 64'd0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b1; ex_mem_write = 1'b1; ex_mem_to_reg = 1'b0;
        ex_result = 64'h40; ex_store_data = 64'h11; ex_rd = 5'd1; ex_reg_write = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset held two cycles with a store presented
        step();
        mon_en = 1;
        step();
        reset = 1'b0;
        idle(1);

        // ALU result passes straight through
        issue(1, KALU, 64'h2A, 64'h0, 5'd3, 1, 0);
        idle(2);

        // Load with two wait states
        ref_mem[64'h100] = 64'hDEAD_BEEF;
        dev_mem[64'h100] = 64'hDEAD_BEEF;
        issue(1, KLD, 64'h100, 64'h0, 5'd7, 1, 2);
        idle(4);

        // Two zero-wait stores back to back
        issue(1, KST, 64'h80, 64'h55, 5'd9, 0, 0);
        issue(1, KST, 64'h88, 64'h66, 5'd10, 0, 0);
        chk("b2b_req", 64'(mem_req), 64'd1);
        chk("b2b_we", 64'(mem_we), 64'd1);
        idle(2);

        // Load never acknowledged: faulted and squashed
        issue(1, KLD, 64'h90, 64'h0, 5'd11, 1, 99);
        idle(8);
        chk("err_sticky", 64'(mem_err), 64'd1);

        // Reset during a wait, then a fresh load
        issue(1, KLD, 64'h98, 64'h0, 5'd12, 1, 3);
        idle(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        issue(1, KLD, 64'h98, 64'h0, 5'd13, 1, 0);
        idle(3);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            int          k, r, dly;
            bit          v;
            logic [63:0] a;
            k = $urandom_range(0, 2);
            v = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 19);
            dly = (r == 0) ? int'(TO) + 1 + $urandom_range(0, 2) : $urandom_range(0, TO);
            a = 64'h200 + (64'($urandom_range(0, 7)) << 3);
            if (k == KALU) a = {$urandom, $urandom};
            issue(v, k, a, {$urandom, $urandom}, 5'($urandom), 1'($urandom_range(0, 1)), dly);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Drain outstanding write-backs
        for (int i = 0; i < 60; i++) begin
            if (exq.size() == 0) break;
            idle(1);
        end
        idle(2);
        if (exq.size() != 0) fail("drain_timeout");
        chk("req_left", 64'(rq.size()), 64'd0);
        chk("mem_err_final", 64'(mem_err), 64'(err_exp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the pipelined 64-bit CPU, directly downstream of EX.
- Holds the EX/MEM pipeline register (ALU/shift result, store data, Rd, MemToReg/RegWrite/MemWrite).
- Drives a variable-latency data-memory req/ack interface, stalls upstream stages while an access is outstanding, and produces the MEM/WB register for write-back.

Parameters:
TIMEOUT, 15, max WAIT cycles without mem_ack before the access is faulted (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ex_valid  in  1  EX holds a valid instruction this cycle
ex_result  in  64  EX logic_result; memory address for loads/stores
ex_store_data  in  64  Db from EX; store data
ex_rd  in  5  destination register
ex_mem_to_reg  in  1  instruction is a load
ex_reg_write  in  1  instruction writes the register file
ex_mem_write  in  1  instruction is a store
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  64  address
mem_wdata  out  64  store data
mem_rdata  in  64  load data, valid when mem_ack=1
mem_ack  in  1  access completes this cycle
stall  out  1  freeze PC/IF/ID/EX and their pipeline registers
wb_valid  out  1  MEM/WB register holds a valid instruction
wb_data  out  64  write-back data
wb_rd  out  5  write-back register
wb_reg_write  out  1  register-file write enable
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, active-high): EX/MEM and MEM/WB valid=0, all data fields 0; FSM=IDLE; wait counter=0; mem_err=0. The mem_req, stall and all wb_* outputs read 0 in the cycle after the reset edge.
- EX/MEM capture: every edge with stall=0 loads all ex_* fields, with valid=ex_valid. With stall=1 the register holds and ex_* inputs are ignored.
- memop = mreg_valid & (mem_to_reg | mem_write).
- mem_req = memop & state!=FAULT & !done. It is combinational from registers and state.
  - mem_we = mreg.mem_write
  - mem_addr = mreg.result
  - mem_wdata = mreg.store_data
  - These outputs are 0 when mem_req=0.
- stall = mem_req & ~mem_ack. An ack with zero wait states produces no stall.
- mem_ack is ignored while mem_req=0.
- FSM states: IDLE, WAIT, FAULT.
  - IDLE: if mem_req & ~mem_ack, go to WAIT with counter=1. Otherwise stay in IDLE.
  - WAIT: on mem_ack, go to IDLE with counter=0. If no ack and counter==TIMEOUT, go to FAULT. Otherwise counter+1.
  - FAULT: lasts one cycle. mem_req=0, stall=0, mem_err set (sticky until reset). The faulted instruction is squashed: MEM/WB gets valid=0 and reg_write=0. Next state is IDLE.
- mem_req is held for at most TIMEOUT+1 consecutive cycles per access.
- MEM/WB capture: every edge where the instruction leaves MEM, i.e. stall=0 and state!=FAULT:
  - wb_valid = mreg_valid
  - wb_rd = mreg.rd
  - wb_reg_write = mreg_valid & mreg.reg_write
  - wb_data = mem_to_reg ? mem_rdata : mreg.result
  - Stores and other non-loads write mreg.result into wb_data.
- MEM/WB during stall: wb_valid=0 and wb_reg_write=0 (bubble). wb_data and wb_rd hold their previous values.
- Latency: an instruction captured into EX/MEM at edge N appears on wb_* after edge N+1+W, where W is the number of stall cycles.
- Back-to-back memops: the EX/MEM reload at the completion edge presents the next access in the following cycle with no idle gap. The `done` term is never set across that boundary.
- Reset mid-access: an access in progress is abandoned. mem_req falls in the cycle after the reset edge and no write-back occurs.

Decomposition:
- cpu_pkg:
  - mem_state_t enum {IDLE, WAIT, FAULT}
  - REG_ADDR_W=5
  - DATA_W=64
  - packed struct exmem_t {valid, result, store_data, rd, mem_to_reg, reg_write, mem_write}
- Sub-module mem_wait_ctrl:
  - Contains the FSM, wait counter and mem_err.
  - Inputs: memop, mem_ack.
  - Outputs: mem_req, stall, fault.
- Top level holds the two pipeline registers and the write-back mux.

Test Plan:
1. Reset held 2 cycles with ex_valid=1 and ex_mem_write=1 -> mem_req=0, stall=0, wb_valid=0, wb_reg_write=0, mem_err=0 throughout.
2. ALU op: ex_result=0x2A, ex_rd=3, ex_reg_write=1 captured at edge N -> after edge N+1: wb_data=0x2A, wb_rd=3, wb_reg_write=1; mem_req never asserted.
3. Load addr 0x100, ack on the 3rd request cycle with rdata 0xDEADBEEF -> mem_req=1 and mem_we=0 for 3 cycles, stall=1 for 2 cycles; after the ack edge: wb_data=0xDEADBEEF, wb_reg_write=1.
4. Store addr 0x80, data 0x55, ack in the same cycle, followed immediately by a second store -> mem_we=1, mem_wdata=0x55, stall never high, second mem_req in the next cycle, wb_reg_write=0.
5. TIMEOUT=4, load never acked -> mem_req high 5 cycles, then a FAULT cycle with mem_req=0, stall=0, mem_err=1 sticky; the load is squashed (wb_valid=0).
6. Reset asserted during WAIT, then a fresh load acked immediately -> mem_req=0 in the cycle after reset, mem_err=0, state IDLE; the new load writes back normally.
